// File: rtl/opf_scoreboard.sv
// opf_scoreboard: operand-fetch stage with RAW lock queue, valid/ready intake, flush and issue register.
// Optional feature macro OPF_BYPASS_EN: a source matching the retiring writeback takes wb_data instead of stalling.
module opf_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int TOKENS = 4,
    parameter int TAGW   = 4,
    localparam int RW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_rd_we,
    input  logic [2:0]      in_fmt,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_npc,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic [RW-1:0]   rf_addr_a,
    output logic [RW-1:0]   rf_addr_b,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_opA,
    output logic [XLEN-1:0] out_opB,
    output logic [XLEN-1:0] out_opC,
    output logic [XLEN-1:0] out_npc,
    output logic [TAGW-1:0] out_tag
);
    // Format codes in my_pkg order: R, I, S, B, U, J.
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic                          held_valid_q, held_valid_d;
    logic [RW-1:0]                 held_rs1_q, held_rs1_d;
    logic [RW-1:0]                 held_rs2_q, held_rs2_d;
    logic [RW-1:0]                 held_rd_q, held_rd_d;
    logic                          held_rd_we_q, held_rd_we_d;
    logic [2:0]                    held_fmt_q, held_fmt_d;
    logic [31:0]                   held_instr_q, held_instr_d;
    logic [XLEN-1:0]               held_npc_q, held_npc_d;
    logic [TAGW-1:0]               held_tag_q, held_tag_d;
    logic [TOKENS-1:0]             q_valid_q, q_valid_d;
    logic [TOKENS-1:0][RW-1:0]     q_rd_q, q_rd_d;
    logic                          out_valid_q, out_valid_d;
    logic [XLEN-1:0]               out_opa_q, out_opa_d;
    logic [XLEN-1:0]               out_opb_q, out_opb_d;
    logic [XLEN-1:0]               out_opc_q, out_opc_d;
    logic [XLEN-1:0]               out_npc_q, out_npc_d;
    logic [TAGW-1:0]               out_tag_q, out_tag_d;

    logic            use1, use2, young1, young2, tail1, tail2;
    logic            busy1, busy2, byp1, byp2, hazard, fire, e0_we;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, data_a, data_b;
    logic            unused_bits;

    assign use1   = !(held_fmt_q == FMT_U || held_fmt_q == FMT_J);
    assign use2   = (held_fmt_q == FMT_R || held_fmt_q == FMT_S || held_fmt_q == FMT_B);
    assign tail1  = q_valid_q[TOKENS-1] && (q_rd_q[TOKENS-1] == held_rs1_q);
    assign tail2  = q_valid_q[TOKENS-1] && (q_rd_q[TOKENS-1] == held_rs2_q);

    // young* covers every entry except the tail, i.e. writes newer than the retiring one.
    always_comb begin
        young1 = 1'b0;
        young2 = 1'b0;
        for (int k = 0; k < TOKENS - 1; k++) begin
            if (q_valid_q[k] && q_rd_q[k] == held_rs1_q) young1 = 1'b1;
            if (q_valid_q[k] && q_rd_q[k] == held_rs2_q) young2 = 1'b1;
        end
    end

`ifdef OPF_BYPASS_EN
    assign busy1 = young1 && (held_rs1_q != '0);
    assign busy2 = young2 && (held_rs2_q != '0);
    assign byp1  = tail1 && !young1 && (held_rs1_q != '0);
    assign byp2  = tail2 && !young2 && (held_rs2_q != '0);
    assign unused_bits = ^held_instr_q[6:0];
`else
    assign busy1 = (young1 || tail1) && (held_rs1_q != '0);
    assign busy2 = (young2 || tail2) && (held_rs2_q != '0);
    assign byp1  = 1'b0;
    assign byp2  = 1'b0;
    assign unused_bits = ^{held_instr_q[6:0], wb_data};
`endif

    assign hazard    = held_valid_q && ((use1 && busy1) || (use2 && busy2));
    assign fire      = held_valid_q && !hazard && !flush;
    assign in_ready  = !held_valid_q || fire;
    assign e0_we     = fire && held_rd_we_q && (held_rd_q != '0);
    assign rf_addr_a = held_rs1_q;
    assign rf_addr_b = held_rs2_q;
    assign data_a    = byp1 ? wb_data : rf_data_a;
    assign data_b    = byp2 ? wb_data : rf_data_b;

    always_comb begin
        imm32 = 32'h0;
        case (held_fmt_q)
            FMT_I: imm32 = {{20{held_instr_q[31]}}, held_instr_q[31:20]};
            FMT_S: imm32 = {{20{held_instr_q[31]}}, held_instr_q[31:25], held_instr_q[11:7]};
            FMT_B: imm32 = {{19{held_instr_q[31]}}, held_instr_q[31], held_instr_q[7],
                            held_instr_q[30:25], held_instr_q[11:8], 1'b0};
            FMT_U: imm32 = {held_instr_q[31:12], 12'h000};
            FMT_J: imm32 = {{11{held_instr_q[31]}}, held_instr_q[31], held_instr_q[19:12],
                            held_instr_q[20], held_instr_q[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
        imm = XLEN'($signed(imm32));
    end

    // Flush wins over a same-cycle accept, so that instruction is dropped.
    always_comb begin
        held_valid_d = held_valid_q;
        held_rs1_d   = held_rs1_q;
        held_rs2_d   = held_rs2_q;
        held_rd_d    = held_rd_q;
        held_rd_we_d = held_rd_we_q;
        held_fmt_d   = held_fmt_q;
        held_instr_d = held_instr_q;
        held_npc_d   = held_npc_q;
        held_tag_d   = held_tag_q;
        if (fire) held_valid_d = 1'b0;
        if (in_valid && in_ready) begin
            held_valid_d = 1'b1;
            held_rs1_d   = in_rs1;
            held_rs2_d   = in_rs2;
            held_rd_d    = in_rd;
            held_rd_we_d = in_rd_we;
            held_fmt_d   = in_fmt;
            held_instr_d = in_instr;
            held_npc_d   = in_npc;
            held_tag_d   = in_tag;
        end
        if (flush) held_valid_d = 1'b0;
    end

    always_comb begin
        q_valid_d   = {q_valid_q[TOKENS-2:0], e0_we};
        q_rd_d      = {q_rd_q[TOKENS-2:0], (e0_we ? held_rd_q : {RW{1'b0}})};
        out_valid_d = fire;
        out_opa_d   = '0;
        out_opb_d   = '0;
        out_opc_d   = '0;
        out_npc_d   = '0;
        out_tag_d   = '0;
        if (fire) begin
            out_opa_d = (held_fmt_q == FMT_U || held_fmt_q == FMT_J) ? held_npc_q : data_a;
            out_opb_d = (held_fmt_q == FMT_R || held_fmt_q == FMT_B) ? data_b : imm;
            out_opc_d = (held_fmt_q == FMT_S) ? data_b : imm;
            out_npc_d = held_npc_q;
            out_tag_d = held_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_rs1_q   <= '0;
            held_rs2_q   <= '0;
            held_rd_q    <= '0;
            held_rd_we_q <= 1'b0;
            held_fmt_q   <= '0;
            held_instr_q <= '0;
            held_npc_q   <= '0;
            held_tag_q   <= '0;
            q_valid_q    <= '0;
            q_rd_q       <= '0;
            out_valid_q  <= 1'b0;
            out_opa_q    <= '0;
            out_opb_q    <= '0;
            out_opc_q    <= '0;
            out_npc_q    <= '0;
            out_tag_q    <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_rs1_q   <= held_rs1_d;
            held_rs2_q   <= held_rs2_d;
            held_rd_q    <= held_rd_d;
            held_rd_we_q <= held_rd_we_d;
            held_fmt_q   <= held_fmt_d;
            held_instr_q <= held_instr_d;
            held_npc_q   <= held_npc_d;
            held_tag_q   <= held_tag_d;
            q_valid_q    <= q_valid_d;
            q_rd_q       <= q_rd_d;
            out_valid_q  <= out_valid_d;
            out_opa_q    <= out_opa_d;
            out_opb_q    <= out_opb_d;
            out_opc_q    <= out_opc_d;
            out_npc_q    <= out_npc_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign wb_valid  = q_valid_q[TOKENS-1];
    assign wb_rd     = q_rd_q[TOKENS-1];
    assign out_valid = out_valid_q;
    assign out_opA   = out_opa_q;
    assign out_opB   = out_opb_q;
    assign out_opC   = out_opc_q;
    assign out_npc   = out_npc_q;
    assign out_tag   = out_tag_q;
endmodule
